// File: rtl/wu_fetch.sv
// WU instruction fetch: issues credit-limited reads to the WU memory and drains returns before done.
// Optional feature: define MGR_WU_FETCH_ADDR_WRAP_EN to let the program counter wrap past the last address.

`ifndef MGR_WU_ADDRESS_WIDTH
`define MGR_WU_ADDRESS_WIDTH 8
`endif
`ifndef MGR_WU_ADDRESS_RANGE
`define MGR_WU_ADDRESS_RANGE `MGR_WU_ADDRESS_WIDTH-1:0
`endif
`ifndef MGR_INSTRUCTION_MEMORY_DEPTH
`define MGR_INSTRUCTION_MEMORY_DEPTH 256
`endif
`ifndef MGR_MGR_ID_RANGE
`define MGR_MGR_ID_RANGE 3:0
`endif

module wu_fetch #(
    parameter int WUF_MAX_OUTSTANDING = 4
) (
    input  logic                          clk,
    input  logic                          reset_poweron,
    input  logic [`MGR_MGR_ID_RANGE]      sys__mgr__mgrId,
    input  logic                          cfg__wuf__start,
    input  logic [`MGR_WU_ADDRESS_RANGE]  cfg__wuf__addr,
    input  logic [`MGR_WU_ADDRESS_WIDTH:0] cfg__wuf__count,
    input  logic                          cfg__wuf__abort,
    output logic [`MGR_WU_ADDRESS_RANGE]  wuf__wum__addr,
    output logic                          wuf__wum__read,
    input  logic                          wum__wuf__stall,
    input  logic                          wum__wud__valid,
    output logic                          wuf__cfg__busy,
    output logic                          wuf__cfg__done,
    output logic                          wuf__cfg__error
);

    localparam int AW = `MGR_WU_ADDRESS_WIDTH;
    localparam int CW = $clog2(WUF_MAX_OUTSTANDING + 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(`MGR_INSTRUCTION_MEMORY_DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [AW-1:0]   r_pc;
    logic [AW:0]     r_remaining;
    logic [CW-1:0]   r_credits;
    logic [AW-1:0]   r_addr;
    logic            r_read;
    logic            r_error;

    logic            w_start_acc;
    logic            w_ret;
    logic [CW-1:0]   w_credits_eff;
    logic [CW-1:0]   w_credits_next;
    logic            w_issue;
    logic            w_last_issue;
    logic            w_overrun;
    logic [AW:0]     w_rem_next;
    logic [AW-1:0]   w_pc_next;

    // Manager id exists only for debug display in simulation builds.
    logic            w_unused_mgr_id;
    assign w_unused_mgr_id = ^sys__mgr__mgrId;

    assign w_start_acc = (r_state == S_IDLE) && cfg__wuf__start && !cfg__wuf__abort;

    // A return with no credits outstanding is stale (e.g. from before a reset) and is dropped.
    // Returns free their credit in the same cycle, so a slot can be reused without a bubble.
    assign w_ret          = wum__wud__valid && (r_credits != '0);
    assign w_credits_eff  = r_credits - CW'(w_ret);
    assign w_issue        = (r_state == S_FETCH) && !wum__wuf__stall &&
                            (w_credits_eff < CW'(WUF_MAX_OUTSTANDING)) && (r_remaining != '0);
    assign w_credits_next = w_credits_eff + CW'(w_issue);

    assign w_rem_next   = r_remaining - 1'b1;
    assign w_pc_next    = (r_pc == LAST_ADDR) ? '0 : r_pc + 1'b1;
    assign w_last_issue = w_issue && (w_rem_next == '0);

`ifdef MGR_WU_FETCH_ADDR_WRAP_EN
    assign w_overrun = 1'b0;
`else
    // Overrun only when words are still owed after reading the last address.
    assign w_overrun = w_issue && (r_pc == LAST_ADDR) && (w_rem_next != '0);
`endif

    // NOTE: asynchronous active-low reset; every sequential assignment is non-blocking.
    always_ff @(posedge clk or negedge reset_poweron) begin
        if (!reset_poweron) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_start_acc) begin
                    w_state_next = (cfg__wuf__count == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                if (cfg__wuf__abort || w_last_issue || w_overrun || (r_remaining == '0)) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_credits_next == '0) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        wuf__cfg__busy = (r_state != S_IDLE);
        wuf__cfg__done = (r_state == S_DONE);
    end

    always_ff @(posedge clk or negedge reset_poweron) begin
        if (!reset_poweron) begin
            r_pc        <= '0;
            r_remaining <= '0;
            r_credits   <= '0;
            r_addr      <= '0;
            r_read      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_credits <= w_credits_next;
            r_read    <= w_issue;
            if (w_start_acc) begin
                r_pc        <= cfg__wuf__addr;
                r_remaining <= cfg__wuf__count;
                r_error     <= 1'b0;
            end else if (w_issue) begin
                r_addr      <= r_pc;
                r_pc        <= w_pc_next;
                r_remaining <= w_overrun ? '0 : w_rem_next;
                if (w_overrun) begin
                    r_error <= 1'b1;
                end
            end
        end
    end

    assign wuf__wum__addr  = r_addr;
    assign wuf__wum__read  = r_read;
    assign wuf__cfg__error = r_error;

endmodule

// File: tb/tb_wu_fetch.sv
// Directed bench for wu_fetch: a 4-credit and a 2-credit instance, each with a fixed-latency memory model.

`ifndef MGR_WU_ADDRESS_WIDTH
`define MGR_WU_ADDRESS_WIDTH 8
`endif
`ifndef MGR_WU_ADDRESS_RANGE
`define MGR_WU_ADDRESS_RANGE `MGR_WU_ADDRESS_WIDTH-1:0
`endif
`ifndef MGR_INSTRUCTION_MEMORY_DEPTH
`define MGR_INSTRUCTION_MEMORY_DEPTH 256
`endif
`ifndef MGR_MGR_ID_RANGE
`define MGR_MGR_ID_RANGE 3:0
`endif

module tb_wu_fetch;

    localparam int AW    = `MGR_WU_ADDRESS_WIDTH;
    localparam int DEPTH = `MGR_INSTRUCTION_MEMORY_DEPTH;

    logic                    clk = 1'b0;
    logic                    reset_poweron = 1'b0;
    logic [`MGR_MGR_ID_RANGE] mgr_id = '0;
    logic                    start1 = 1'b0;
    logic                    start2 = 1'b0;
    logic [AW-1:0]           cfg_addr = '0;
    logic [AW:0]             cfg_count = '0;
    logic                    abort = 1'b0;
    logic                    stall = 1'b0;
    logic                    inj1 = 1'b0;

    logic [AW-1:0] addr1, addr2;
    logic          read1, read2, busy1, busy2, done1, done2, err1, err2;
    logic          valid1, valid2;
    logic [1:0]    pipe1 = '0;
    logic [1:0]    pipe2 = '0;

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;

    int rd_addr[$];
    int rd_cyc[$];
    int n_valid;
    int max_if;
    int done_cyc;
    int err_at_done;
    int busy_at_done;

    wu_fetch #(.WUF_MAX_OUTSTANDING(4)) u_dut1 (
        .clk(clk), .reset_poweron(reset_poweron), .sys__mgr__mgrId(mgr_id),
        .cfg__wuf__start(start1), .cfg__wuf__addr(cfg_addr), .cfg__wuf__count(cfg_count),
        .cfg__wuf__abort(abort), .wuf__wum__addr(addr1), .wuf__wum__read(read1),
        .wum__wuf__stall(stall), .wum__wud__valid(valid1), .wuf__cfg__busy(busy1),
        .wuf__cfg__done(done1), .wuf__cfg__error(err1)
    );

    wu_fetch #(.WUF_MAX_OUTSTANDING(2)) u_dut2 (
        .clk(clk), .reset_poweron(reset_poweron), .sys__mgr__mgrId(mgr_id),
        .cfg__wuf__start(start2), .cfg__wuf__addr(cfg_addr), .cfg__wuf__count(cfg_count),
        .cfg__wuf__abort(abort), .wuf__wum__addr(addr2), .wuf__wum__read(read2),
        .wum__wuf__stall(stall), .wum__wud__valid(valid2), .wuf__cfg__busy(busy2),
        .wuf__cfg__done(done2), .wuf__cfg__error(err2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: a read issued in cycle T returns valid in cycle T+3.
    always @(posedge clk) begin
        pipe1 <= {pipe1[0], read1};
        pipe2 <= {pipe2[0], read2};
    end
    assign valid1 = pipe1[1] | inj1;
    assign valid2 = pipe2[1];

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Runs one program on the selected instance, recording reads, valids and the done pulse.
    task automatic run(input string tag, input bit sel2, input int a, input int cnt,
                       input int st_lo, input int st_hi, input int ab_k, input int rs_k,
                       output int s);
        int n_rd;
        logic rd, vl, dn;
        logic [AW-1:0] ad;
        rd_addr.delete();
        rd_cyc.delete();
        n_valid  = 0;
        max_if   = 0;
        done_cyc = -1;
        n_rd     = 0;
        s        = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            rd = sel2 ? read2 : read1;
            ad = sel2 ? addr2 : addr1;
            vl = sel2 ? valid2 : valid1;
            dn = sel2 ? done2 : done1;
            if (k > 0) begin
                if (rd) begin
                    rd_addr.push_back(int'(ad));
                    rd_cyc.push_back(cyc);
                    n_rd++;
                end
                if (vl) n_valid++;
                if (n_rd - n_valid > max_if) max_if = n_rd - n_valid;
                if (dn) begin
                    done_cyc     = cyc;
                    err_at_done  = int'(sel2 ? err2 : err1);
                    busy_at_done = int'(sel2 ? busy2 : busy1);
                end
            end
            if (done_cyc >= 0) break;
            start1    = !sel2 && (k == 0 || k == rs_k);
            start2    = sel2 && (k == 0 || k == rs_k);
            cfg_addr  = AW'(a);
            cfg_count = (AW+1)'(cnt);
            stall     = (k >= st_lo) && (k <= st_hi);
            abort     = (k == ab_k);
            if (k == 0) s = cyc;
        end
        start1 = 1'b0;
        start2 = 1'b0;
        stall  = 1'b0;
        abort  = 1'b0;
        check({tag, "_done_seen"}, int'(done_cyc >= 0), 1);
        if (done_cyc >= 0) begin
            check({tag, "_busy_at_done"}, busy_at_done, 1);
            @(negedge clk);
            check({tag, "_busy_after"}, int'(sel2 ? busy2 : busy1), 0);
        end
    endtask

    initial begin
        int s;
        int n_done;

        // Outputs held low while in reset.
        repeat (3) @(negedge clk);
        check("rst_read", int'(read1), 0);
        check("rst_addr", int'(addr1), 0);
        check("rst_busy", int'(busy1), 0);
        check("rst_done", int'(done1), 0);
        check("rst_error", int'(err1), 0);
        reset_poweron = 1'b1;
        @(negedge clk);

        // Start together with abort is not accepted.
        start1 = 1'b1; abort = 1'b1; cfg_count = 3;
        @(negedge clk);
        start1 = 1'b0; abort = 1'b0;
        check("start_abort_busy", int'(busy1), 0);
        @(negedge clk);
        check("start_abort_read", int'(read1), 0);

        // Basic fetch, with a second start mid-program that must be ignored.
        run("basic", 1'b0, 'h10, 5, 99, 0, -1, 2, s);
        check("basic_nreads", rd_addr.size(), 5);
        for (int i = 0; i < rd_addr.size() && i < 5; i++) begin
            check($sformatf("basic_addr%0d", i), rd_addr[i], 'h10 + i);
            check($sformatf("basic_cyc%0d", i), rd_cyc[i], s + 2 + i);
        end
        check("basic_done_cyc", done_cyc, s + 9);

        // Two credits: two reads on, one off.
        run("credit", 1'b1, 'h20, 6, 99, 0, -1, -1, s);
        check("credit_nreads", rd_addr.size(), 6);
        for (int i = 0; i < rd_addr.size() && i < 6; i++) begin
            check($sformatf("credit_addr%0d", i), rd_addr[i], 'h20 + i);
            check($sformatf("credit_cyc%0d", i), rd_cyc[i], s + 2 + i + i / 2);
        end
        check("credit_max_inflight_le2", int'(max_if <= 2), 1);
        check("credit_done_cyc", done_cyc, s + 12);

        // Stall during program cycles 2..5.
        run("stall", 1'b0, 'h40, 8, 2, 5, -1, -1, s);
        check("stall_nreads", rd_addr.size(), 8);
        for (int i = 0; i < rd_addr.size() && i < 8; i++) begin
            check($sformatf("stall_addr%0d", i), rd_addr[i], 'h40 + i);
            check($sformatf("stall_cyc%0d", i), rd_cyc[i], (i == 0) ? s + 2 : s + 6 + i);
        end
        check("stall_done_cyc", done_cyc, s + 16);

        // Abort on the third issue.
        run("abort", 1'b0, 'h80, 10, 99, 0, 3, -1, s);
        check("abort_nreads", rd_addr.size(), 3);
        for (int i = 0; i < rd_addr.size() && i < 3; i++) begin
            check($sformatf("abort_addr%0d", i), rd_addr[i], 'h80 + i);
        end
        check("abort_valids_at_done", n_valid, 3);
        check("abort_done_cyc", done_cyc, s + 7);

        // Address overrun at the top of memory.
        run("overrun", 1'b0, DEPTH - 2, 4, 99, 0, -1, -1, s);
`ifdef MGR_WU_FETCH_ADDR_WRAP_EN
        check("overrun_nreads", rd_addr.size(), 4);
        for (int i = 0; i < rd_addr.size() && i < 4; i++) begin
            check($sformatf("overrun_addr%0d", i), rd_addr[i], (DEPTH - 2 + i) % DEPTH);
        end
        check("overrun_error", err_at_done, 0);
        check("overrun_done_cyc", done_cyc, s + 8);
`else
        check("overrun_nreads", rd_addr.size(), 2);
        for (int i = 0; i < rd_addr.size() && i < 2; i++) begin
            check($sformatf("overrun_addr%0d", i), rd_addr[i], DEPTH - 2 + i);
        end
        check("overrun_error", err_at_done, 1);
        check("overrun_done_cyc", done_cyc, s + 6);
        check("overrun_error_sticky", int'(err1), 1);
`endif

        // Zero-length program goes straight to done and clears the error flag.
        run("count0", 1'b0, 'h05, 0, 99, 0, -1, -1, s);
        check("count0_nreads", rd_addr.size(), 0);
        check("count0_done_cyc", done_cyc, s + 1);
        check("count0_error", err_at_done, 0);

        // Reset with two reads in flight.
        @(negedge clk);
        start1 = 1'b1; cfg_addr = 'h60; cfg_count = 8;
        @(negedge clk);
        start1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("midrst_read_before", int'(read1), 1);
        #1 reset_poweron = 1'b0;
        #1;
        check("midrst_read", int'(read1), 0);
        check("midrst_addr", int'(addr1), 0);
        check("midrst_busy", int'(busy1), 0);
        check("midrst_done", int'(done1), 0);
        check("midrst_error", int'(err1), 0);
        @(negedge clk);
        reset_poweron = 1'b1;
        n_done = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (done1) n_done++;
            inj1 = (k == 1);
        end
        inj1 = 1'b0;
        @(negedge clk);
        check("midrst_no_done", n_done, 0);
        check("midrst_credits", int'(u_dut1.r_credits), 0);
        check("midrst_busy_after", int'(busy1), 0);

        run("post_rst", 1'b0, 'h70, 1, 99, 0, -1, -1, s);
        check("post_rst_nreads", rd_addr.size(), 1);
        if (rd_addr.size() > 0) check("post_rst_addr", rd_addr[0], 'h70);
        check("post_rst_done_cyc", done_cyc, s + 5);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/wu_fetch.md
WU_FETCH -- requirements
Module: wu_fetch

Interface
REQ-001 SHALL have parameter WUF_MAX_OUTSTANDING, default 4, the maximum number of reads in flight to the WU memory (range 1..7).
REQ-002 SHALL have port clk, input, 1, clock.
REQ-003 SHALL have port reset_poweron, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port sys__mgr__mgrId, input, `MGR_MGR_ID_RANGE, manager id, used only for debug display.
REQ-005 SHALL have port cfg__wuf__start, input, 1, single-cycle program start request.
REQ-006 SHALL have port cfg__wuf__addr, input, `MGR_WU_ADDRESS_RANGE, first instruction word address.
REQ-007 SHALL have port cfg__wuf__count, input, `MGR_WU_ADDRESS_WIDTH+1, number of words to fetch.
REQ-008 SHALL have port cfg__wuf__abort, input, 1, stop issuing and drain.
REQ-009 SHALL have port wuf__wum__addr, output, `MGR_WU_ADDRESS_RANGE, read address, registered.
REQ-010 SHALL have port wuf__wum__read, output, 1, read strobe, registered.
REQ-011 SHALL have port wum__wuf__stall, input, 1, memory/decode back-pressure.
REQ-012 SHALL have port wum__wud__valid, input, 1, returned instruction word, used for credit return.
REQ-013 SHALL have port wuf__cfg__busy, output, 1, high in any state other than IDLE.
REQ-014 SHALL have port wuf__cfg__done, output, 1, one-cycle pulse on completion.
REQ-015 SHALL have port wuf__cfg__error, output, 1, sticky address-overrun flag, cleared by the next accepted start.

Function
REQ-016 SHALL implement the states IDLE, FETCH, DRAIN and DONE.
REQ-017 IDLE: cfg__wuf__start=1 with abort=0 SHALL load pc=cfg__wuf__addr and remaining=cfg__wuf__count, then go to FETCH; if count=0, SHALL go directly to DONE.
REQ-018 FETCH: a read SHALL be issued in a cycle iff stall=0, credits<WUF_MAX_OUTSTANDING and remaining>0.
- On issue: read=1, addr=pc, pc+1, remaining-1, credits+1.
REQ-019 When remaining reaches 0, or abort=1, the state SHALL go from FETCH to DRAIN; a read issued in the same cycle still counts.
REQ-020 DRAIN SHALL wait for credits=0, then go to DONE; DONE SHALL pulse done for one cycle, then go to IDLE.
REQ-021 Credit counter: each wum__wud__valid=1 SHALL decrement it; simultaneous issue and return SHALL leave it unchanged.
- The counter SHALL never underflow; a valid with credits=0 is ignored.
REQ-022 Round-trip latency is 3 cycles (read at T gives valid at T+3); with WUF_MAX_OUTSTANDING>=3 and stall=0 the block SHALL sustain one read per cycle.
REQ-023 wuf__wum__read SHALL be 0 whenever no read is issued; wuf__wum__addr SHALL hold its last value when read=0.
REQ-024 cfg__wuf__start outside IDLE SHALL be ignored; abort in IDLE or DONE SHALL be ignored.
REQ-025 Stall SHALL only suppress new issues; it SHALL NOT alter pc, remaining or credits.

Reset
REQ-026 reset_poweron=0 SHALL asynchronously force IDLE with pc=0, remaining=0, credits=0.
REQ-027 During reset, all outputs SHALL be 0: read, addr, busy, done and error.
REQ-028 Reset asserted mid-program SHALL abandon the program without a done pulse; valids returning after reset release SHALL be ignored because credits=0.

Configuration
REQ-029 Macro MGR_WU_FETCH_ADDR_WRAP_EN controls what happens when pc passes the last memory address (`MGR_INSTRUCTION_MEMORY_DEPTH-1).
- Defined: pc SHALL wrap to 0 and fetching SHALL continue, with no error.
- Undefined: the block SHALL issue the read at the last address, then set error=1 and go to DRAIN, discarding the remaining count.

Verification
REQ-030 Basic fetch: start addr=0x10, count=5, stall=0, memory model 3-cycle latency -> reads at 0x10..0x14 on 5 consecutive cycles; done pulses 3 cycles after the last read; busy falls with done.
REQ-031 Credit limit: WUF_MAX_OUTSTANDING=2, count=6 -> no more than 2 reads in flight at any time; issue pattern 2 on, 1 off; 6 reads total.
REQ-032 Stall: stall=1 for cycles 2-5 of an 8-word program -> no read while stalled; the address sequence is contiguous with no skips or repeats.
REQ-033 Abort: abort at the 3rd issue of a count=10 program -> exactly 3 reads; done after the 3rd valid returns.
REQ-034 Overrun: start addr=DEPTH-2, count=4 -> with macro, addresses DEPTH-2, DEPTH-1, 0, 1 and error=0; without macro, 2 reads then error=1 and done.
REQ-035 Reset: reset_poweron=0 with 2 reads in flight -> outputs 0 immediately; after release, late valids leave credits=0; a new start count=1 completes normally.
